key_debounce_array: RTL and testbench
=====================================

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent key channels, range 1..32.
REQ-002 Parameter DEB_CYCLES, default 1_000_000: stable-time requirement in clocks (20 ms at 50 MHz), minimum 2.
REQ-003 Parameter LONG_CYCLES, default 50_000_000: hold time from press to long-press event (1 s).
REQ-004 Parameter REPEAT_CYCLES, default 10_000_000: auto-repeat period after long-press (200 ms); value 0 disables repeat.
REQ-005 Parameter IDLE_LEVEL, default 1: released pin level; pressed = ~IDLE_LEVEL (active-low keys by default).
REQ-006 sys_clk  input  1  system clock.
REQ-007 sys_rst_n  input  1  reset, asynchronous, active-low; clock sys_clk.
REQ-008 key_in  input  N_KEYS  raw asynchronous key pins.
REQ-009 key_level  output  N_KEYS  debounced pin level per channel.
REQ-010 press_pulse  output  N_KEYS  one-cycle strobe on a debounced press.
REQ-011 release_pulse  output  N_KEYS  one-cycle strobe on a debounced release.
REQ-012 long_pulse  output  N_KEYS  one-cycle strobe when a key has been held LONG_CYCLES.
REQ-013 repeat_pulse  output  N_KEYS  one-cycle strobe every REPEAT_CYCLES after long_pulse while held.

Function
REQ-014 Each key_in bit SHALL pass through a 2-flop synchronizer before any comparison.
REQ-015 Per channel: when the synchronized level differs from the stored raw level, the stored level SHALL update and the debounce counter SHALL reload to DEB_CYCLES; otherwise a nonzero counter SHALL decrement, saturating at 0.
REQ-016 At counter == 1, if the stored raw level differs from key_level, key_level SHALL take it on the next edge, with press_pulse or release_pulse asserted for exactly that cycle.
REQ-017 Latency: a clean transition first sampled at edge 0 SHALL appear on key_level and its pulse at edge DEB_CYCLES+2.
REQ-018 A glitch shorter than DEB_CYCLES stable clocks, or a bounce returning to the prior level, SHALL produce no level change and no pulse.
REQ-019 Hold FSM per channel: IDLE -> HELD on press_pulse (hold counter cleared); HELD -> LONG when the counter reaches LONG_CYCLES-1, asserting long_pulse; in LONG, repeat_pulse every REPEAT_CYCLES clocks (counter reloads); any state -> IDLE on release_pulse.
REQ-020 release_pulse SHALL be emitted regardless of FSM state; a release in the same cycle a long/repeat event would fire SHALL suppress that event.
REQ-021 Counters SHALL be $clog2-sized to their maximum parameter value and SHALL never wrap.
REQ-022 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be reported in the same cycle.
REQ-023 At most one of press/release/long/repeat SHALL be high per channel per cycle.

Reset
REQ-024 On sys_rst_n low: synchronizers, stored raw level and key_level = IDLE_LEVEL on every bit; all counters 0; FSMs IDLE; all pulse outputs 0.
REQ-025 Reset assertion mid-debounce or mid-hold SHALL abort immediately; no pulse SHALL be generated by the reset or by its release while pins are idle.

Structure
REQ-026 Package key_pkg SHALL hold hold-FSM state encodings (IDLE, HELD, LONG) and default timing constants.
REQ-027 One sub-module key_debounce_ch (synchronizer, debounce counter, hold FSM for one key) SHALL be instantiated N_KEYS times by a generate loop.

Verification (DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, N_KEYS=4)
REQ-028 key_in[0] 1->0 at edge 0, held -> key_level[0]=0 and press_pulse[0]=1 for one cycle at edge 6.
REQ-029 key_in[1] low for 3 clocks then high -> no pulses; key_level[1] stays 1.
REQ-030 key_in[2] held low 60 clocks -> press at edge 6, long_pulse at press+20, repeat_pulse at +8 and +16 thereafter; release_pulse after key returns high.
REQ-031 key_in[0] and key_in[3] pressed same edge -> press_pulse = 4'b1001 in a single cycle.
REQ-032 Reset asserted during HELD on key_in[2] -> all outputs at reset values next cycle; with pin still low, release of reset yields press_pulse after DEB_CYCLES+2 edges.
REQ-033 REPEAT_CYCLES=0 with 60-clock hold -> long_pulse once, no repeat_pulse.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants for the key debounce block: hold-FSM encodings and default timing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package key_pkg;

    // Hold FSM encodings (kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    // Default timing at 50 MHz: 20 ms debounce, 1 s long press, 200 ms repeat
    localparam int DEF_N_KEYS        = 4;
    localparam int DEF_DEB_CYCLES    = 1_000_000;
    localparam int DEF_LONG_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;

    // Bits needed to hold any value in 0..max_val (at least one bit)
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce counter, hold FSM (press/release/long/repeat).
// Latency: clean pin edge sampled at edge 0 shows on key_level and its strobe at edge DEB_CYCLES+2.
// Backpressure: none; all event outputs are single-cycle strobes that cannot be stalled.
// Ports: sys_clk, sys_rst_n (async active-low), key_in (raw pin), key_level (debounced level),
//        press_pulse / release_pulse / long_pulse / repeat_pulse (one-cycle strobes).
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit IDLE_LEVEL    = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DW   = cnt_width(DEB_CYCLES);
    localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW   = cnt_width(HMAX);

    localparam logic [DW-1:0] DEB_LOAD    = DW'(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST    = DW'(1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          raw_q, raw_d;
    logic          level_q, level_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;

    logic settle;
    logic press_ev;
    logic release_ev;

    always_comb begin
        sync1_d    = key_in;
        sync2_d    = sync1_q;
        raw_d      = raw_q;
        deb_cnt_d  = deb_cnt_q;
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        // Any movement on the synchronized pin restarts the stability window
        if (sync2_q != raw_q) begin
            raw_d     = sync2_q;
            deb_cnt_d = DEB_LOAD;
        end else if (deb_cnt_q != '0) begin
            deb_cnt_d = deb_cnt_q - 1'b1;
        end

        // Last clock of the window: commit the raw level if it is a real change
        settle     = (deb_cnt_q == DEB_LAST) && (raw_q != level_q);
        level_d    = settle ? raw_q : level_q;
        press_ev   = settle && (raw_q != IDLE_LEVEL);
        release_ev = settle && (raw_q == IDLE_LEVEL);
        press_d    = press_ev;
        release_d  = release_ev;

        // Release wins over a long/repeat event landing on the same edge
        if (release_ev) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press_ev) begin
                        state_d    = ST_HELD;
                        hold_cnt_d = '0;
                    end
                end
                ST_HELD: begin
                    if (hold_cnt_q == LONG_LAST) begin
                        state_d    = ST_LONG;
                        hold_cnt_d = '0;
                        long_d     = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_LONG: begin
                    // With repeat disabled the counter simply parks at zero
                    if (REPEAT_CYCLES != 0) begin
                        if (hold_cnt_q == REPEAT_LAST) begin
                            hold_cnt_d = '0;
                            repeat_d   = 1'b1;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q    <= IDLE_LEVEL;
            sync2_q    <= IDLE_LEVEL;
            raw_q      <= IDLE_LEVEL;
            level_q    <= IDLE_LEVEL;
            deb_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            raw_q      <= raw_d;
            level_q    <= level_d;
            deb_cnt_q  <= deb_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/key_debounce_array.sv
// Array of N_KEYS independent debounced keys with press/release/long-press/auto-repeat strobes.
// Latency: DEB_CYCLES+2 clocks from first pin sample to key_level/press/release; long at press+LONG_CYCLES.
// Backpressure: none; strobes are one cycle wide and every channel reports in the same cycle.
// Ports: sys_clk, sys_rst_n (async active-low), key_in[N_KEYS] raw pins,
//        key_level / press_pulse / release_pulse / long_pulse / repeat_pulse [N_KEYS].
module key_debounce_array
    import key_pkg::*;
#(
    parameter int N_KEYS        = DEF_N_KEYS,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit IDLE_LEVEL    = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] repeat_pulse
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYCLES   (DEB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .IDLE_LEVEL   (IDLE_LEVEL)
        ) u_ch (
            .sys_clk      (sys_clk),
            .sys_rst_n    (sys_rst_n),
            .key_in       (key_in[g]),
            .key_level    (key_level[g]),
            .press_pulse  (press_pulse[g]),
            .release_pulse(release_pulse[g]),
            .long_pulse   (long_pulse[g]),
            .repeat_pulse (repeat_pulse[g])
        );
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: directed scenarios plus random pin activity on two instances
// (auto-repeat enabled and disabled), checked every clock against a window/arithmetic model.
// Backpressure: n/a.
module tb_key_debounce_array;

    localparam int N    = 4;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;
    localparam int HLEN = DEB + 3;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic [N-1:0] key_in = '1;

    logic [N-1:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
    logic [N-1:0] lvl_b, prs_b, rel_b, lng_b, rep_b;

    key_debounce_array #(
        .N_KEYS(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .IDLE_LEVEL(1'b1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
        .key_level(lvl_a), .press_pulse(prs_a), .release_pulse(rel_a),
        .long_pulse(lng_a), .repeat_pulse(rep_a)
    );

    key_debounce_array #(
        .N_KEYS(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(0), .IDLE_LEVEL(1'b1)
    ) dut_norep (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
        .key_level(lvl_b), .press_pulse(prs_b), .release_pulse(rel_b),
        .long_pulse(lng_b), .repeat_pulse(rep_b)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_no = 0;

    // Reference model state: recent pin samples (index 0 = this edge) and press bookkeeping
    logic [N-1:0] hist[$];
    logic [N-1:0] m_level, m_press, m_release, m_long, m_rep;
    bit           held[N];
    int           p_edge[N];

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, edge_no);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < HLEN; k++) hist.push_back('1);
        m_level = '1; m_press = '0; m_release = '0; m_long = '0; m_rep = '0;
        for (int c = 0; c < N; c++) begin
            held[c] = 1'b0;
            p_edge[c] = 0;
        end
    endtask

    // A new level is accepted once DEB consecutive samples agree; the last of them is
    // three edges old (two synchronizer stages plus the registered output).
    task automatic model_edge();
        hist.push_front(key_in);
        if (hist.size() > HLEN) void'(hist.pop_back());
        m_press = '0; m_release = '0; m_long = '0; m_rep = '0;
        for (int c = 0; c < N; c++) begin
            logic v;
            bit   stable;
            int   d;
            v = hist[3][c];
            stable = 1'b1;
            for (int k = 3; k <= DEB + 2; k++) if (hist[k][c] !== v) stable = 1'b0;
            if (stable && v !== m_level[c]) begin
                m_level[c] = v;
                if (v == 1'b0) begin
                    m_press[c] = 1'b1;
                    held[c] = 1'b1;
                    p_edge[c] = edge_no;
                end else begin
                    m_release[c] = 1'b1;
                    held[c] = 1'b0;
                end
            end else if (held[c]) begin
                d = edge_no - p_edge[c];
                if (d == LONG) m_long[c] = 1'b1;
                else if (d > LONG && ((d - LONG) % REP) == 0) m_rep[c] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("a_level",   lvl_a, m_level);
        chk("a_press",   prs_a, m_press);
        chk("a_release", rel_a, m_release);
        chk("a_long",    lng_a, m_long);
        chk("a_repeat",  rep_a, m_rep);
        chk("b_level",   lvl_b, m_level);
        chk("b_press",   prs_b, m_press);
        chk("b_release", rel_b, m_release);
        chk("b_long",    lng_b, m_long);
        chk("b_repeat",  rep_b, '0);
        chk("one_hot_ch", (prs_a & rel_a) | ((prs_a | rel_a) & (lng_a | rep_a)) | (lng_a & rep_a), '0);
    endtask

    task automatic step();
        @(posedge sys_clk);
        edge_no++;
        if (sys_rst_n) model_edge();
        else model_reset();
        #1;
        check_all();
    endtask

    initial begin
        int base, n_long_a, n_rep_a, n_long_b, n_rep_b, t_press, t_long, t_rep1, t_rel, found;
        logic seen;
        int run_left[N];

        // Reset state
        model_reset();
        repeat (3) step();
        chk("reset_level", lvl_a, 4'b1111);
        sys_rst_n = 1'b1;
        repeat (5) step();

        // Clean press on key 0: level and strobe at edge DEB+2
        key_in[0] = 1'b0;
        repeat (DEB + 2) step();
        chk("k0_before_press", prs_a, 4'b0000);
        step();
        chk("k0_press_edge", prs_a, 4'b0001);
        chk("k0_level", lvl_a, 4'b1110);
        step();
        chk("k0_press_one_cycle", prs_a, 4'b0000);

        // Three-clock glitch on key 1: nothing may happen
        seen = 1'b0;
        key_in[1] = 1'b0;
        repeat (3) begin step(); seen |= prs_a[1] | rel_a[1] | ~lvl_a[1]; end
        key_in[1] = 1'b1;
        repeat (12) begin step(); seen |= prs_a[1] | rel_a[1] | ~lvl_a[1]; end
        chk("k1_glitch_quiet", {3'b000, seen}, 4'b0000);

        // Long hold on key 2: press, long, repeats, release (a repeat coincides with release)
        n_long_a = 0; n_rep_a = 0; n_long_b = 0; n_rep_b = 0;
        t_press = -1; t_long = -1; t_rep1 = -1; t_rel = -1;
        key_in[2] = 1'b0;
        base = edge_no + 1;
        for (int i = 0; i < 90; i++) begin
            if (i == 60) key_in[2] = 1'b1;
            step();
            if (prs_a[2] && t_press < 0) t_press = edge_no - base;
            if (lng_a[2]) begin n_long_a++; t_long = edge_no - base; end
            if (rep_a[2]) begin n_rep_a++; if (t_rep1 < 0) t_rep1 = edge_no - base; end
            if (rel_a[2] && t_rel < 0) t_rel = edge_no - base;
            if (lng_b[2]) n_long_b++;
            if (rep_b[2]) n_rep_b++;
        end
        chk_int("k2_press_time", t_press, DEB + 2);
        chk_int("k2_long_time", t_long, DEB + 2 + LONG);
        chk_int("k2_rep1_time", t_rep1, DEB + 2 + LONG + REP);
        chk_int("k2_release_time", t_rel, 60 + DEB + 2);
        chk_int("k2_long_count", n_long_a, 1);
        chk_int("k2_rep_count", n_rep_a, 4);
        chk_int("norep_long_count", n_long_b, 1);
        chk_int("norep_rep_count", n_rep_b, 0);

        // Release key 0, then keys 0 and 3 together
        key_in[0] = 1'b1;
        repeat (12) step();
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        repeat (DEB + 2) step();
        step();
        chk("k0k3_same_cycle", prs_a, 4'b1001);

        // Reset in the middle of a hold on key 2, pin stays low through reset
        key_in[2] = 1'b0;
        repeat (12) step();
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_async_level", lvl_a, 4'b1111);
        repeat (3) step();
        sys_rst_n = 1'b1;
        found = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (prs_a[2] && found < 0) found = k;
        end
        chk_int("press_after_reset", found, DEB + 2);
        key_in = '1;
        repeat (15) step();

        // Random pin activity: short glitches and long holds on every channel
        for (int c = 0; c < N; c++) run_left[c] = 0;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < N; c++) begin
                if (run_left[c] == 0) begin
                    key_in[c] = 1'($urandom_range(0, 1));
                    run_left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DEB)
                                                              : $urandom_range(DEB, 70);
                end
                run_left[c]--;
            end
            if (i == 1000) begin
                sys_rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
            end
            if (i == 1003) sys_rst_n = 1'b1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
